// File: rtl/cc_poscollision_monitor.sv
// Registered multi-player collision monitor: compares the bottom obstacle row against
// each player's position on every frame tick, deducts lives once per contact, latches game-over.
module cc_poscollision_monitor #(
    parameter int PosCOLLISION_DATAWIDTH  = 8,
    parameter int PosCOLLISION_NUMPLAYERS = 2,
    parameter int PosCOLLISION_LIVES      = 3,
    parameter int PosCOLLISION_MATCHMODE  = 1,
    localparam int LW = $clog2(PosCOLLISION_LIVES + 1)
) (
    input  logic                                                  CC_PosCOLLISION_CLOCK_50,
    input  logic                                                  CC_PosCOLLISION_RESET_InHigh,
    input  logic                                                  CC_PosCOLLISION_clear_InHigh,
    input  logic                                                  CC_PosCOLLISION_frametick_InHigh,
    input  logic [PosCOLLISION_DATAWIDTH-1:0]                     CC_PosCOLLISION_fila0,
    input  logic [PosCOLLISION_NUMPLAYERS*PosCOLLISION_DATAWIDTH-1:0] CC_PosCOLLISION_posjug,
    output logic [PosCOLLISION_NUMPLAYERS-1:0]                    CC_PosCOLLISION_OutBUS,
    output logic [PosCOLLISION_NUMPLAYERS-1:0]                    CC_PosCOLLISION_hit,
    output logic [PosCOLLISION_NUMPLAYERS*LW-1:0]                 CC_PosCOLLISION_lives,
    output logic [PosCOLLISION_NUMPLAYERS-1:0]                    CC_PosCOLLISION_gameover,
    output logic                                                  CC_PosCOLLISION_allover
);

    localparam int DW = PosCOLLISION_DATAWIDTH;
    localparam int NP = PosCOLLISION_NUMPLAYERS;
    localparam logic [LW-1:0] LIVES_INIT = LW'(PosCOLLISION_LIVES);
    localparam logic [LW-1:0] ONE_LIFE   = LW'(1);

    logic [NP-1:0] coll;

    logic [NP-1:0] outbus_q, outbus_d;
    logic [NP-1:0] hit_q, hit_d;
    logic [NP-1:0] gameover_q, gameover_d;
    logic [NP-1:0] prev_q, prev_d;
    logic [LW-1:0] lives_q [NP];
    logic [LW-1:0] lives_d [NP];

    // An all-zero player vector means the player is absent and never collides.
    for (genvar k = 0; k < NP; k++) begin : g_coll
        logic [DW-1:0] pos;
        assign pos = CC_PosCOLLISION_posjug[k*DW +: DW];
        if (PosCOLLISION_MATCHMODE == 0) begin : g_eq
            assign coll[k] = (|pos) && (CC_PosCOLLISION_fila0 == pos);
        end else begin : g_ov
            assign coll[k] = |(CC_PosCOLLISION_fila0 & pos);
        end
        assign CC_PosCOLLISION_lives[k*LW +: LW] = lives_q[k];
    end

    always_comb begin
        outbus_d   = outbus_q;
        hit_d      = '0;
        gameover_d = gameover_q;
        prev_d     = prev_q;
        for (int k = 0; k < NP; k++) begin
            lives_d[k] = lives_q[k];
        end

        if (CC_PosCOLLISION_clear_InHigh) begin
            outbus_d   = '1;
            gameover_d = '0;
            prev_d     = '0;
            for (int k = 0; k < NP; k++) begin
                lives_d[k] = LIVES_INIT;
            end
        end else if (CC_PosCOLLISION_frametick_InHigh) begin
            // A life is lost only on the rising edge of contact, and never after game-over.
            for (int k = 0; k < NP; k++) begin
                outbus_d[k] = ~coll[k];
                prev_d[k]   = coll[k];
                if (coll[k] && !prev_q[k] && !gameover_q[k]) begin
                    lives_d[k] = lives_q[k] - ONE_LIFE;
                    hit_d[k]   = 1'b1;
                    if (lives_q[k] == ONE_LIFE) begin
                        gameover_d[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CC_PosCOLLISION_CLOCK_50 or posedge CC_PosCOLLISION_RESET_InHigh) begin
        if (CC_PosCOLLISION_RESET_InHigh) begin
            outbus_q   <= '1;
            hit_q      <= '0;
            gameover_q <= '0;
            prev_q     <= '0;
            for (int k = 0; k < NP; k++) begin
                lives_q[k] <= LIVES_INIT;
            end
        end else begin
            outbus_q   <= outbus_d;
            hit_q      <= hit_d;
            gameover_q <= gameover_d;
            prev_q     <= prev_d;
            for (int k = 0; k < NP; k++) begin
                lives_q[k] <= lives_d[k];
            end
        end
    end

    assign CC_PosCOLLISION_OutBUS   = outbus_q;
    assign CC_PosCOLLISION_hit      = hit_q;
    assign CC_PosCOLLISION_gameover = gameover_q;
    assign CC_PosCOLLISION_allover  = &gameover_q;

endmodule

// File: tb/tb_cc_poscollision_monitor.sv
// Scoreboard bench: two monitors (overlap and exact-match rules) share one stimulus stream
// and are compared every cycle against a behavioural model of the game rules.
module tb_cc_poscollision_monitor;

    typedef struct packed {
        logic [1:0] ob;
        logic [1:0] hit;
        logic [1:0] go;
        logic [3:0] lv;
        logic       all;
    } expT;

    typedef struct packed {
        expT m1;
        expT m0;
    } pairT;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        tick = 1'b0;
    logic [7:0]  fila0 = '0;
    logic [15:0] posjug = '0;

    logic [1:0] ob1, hit1, go1, ob0, hit0, go0;
    logic [3:0] lv1, lv0;
    logic       all1, all0;

    int total = 0;
    int bad = 0;

    // Model state, first index: 1 = overlap monitor, 0 = exact-match monitor.
    int mLives [2][2];
    bit mGo    [2][2];
    bit mPrev  [2][2];
    bit mOb    [2][2];
    bit mHit   [2][2];

    pairT expQ [$];

    cc_poscollision_monitor #(
        .PosCOLLISION_DATAWIDTH(8), .PosCOLLISION_NUMPLAYERS(2),
        .PosCOLLISION_LIVES(3), .PosCOLLISION_MATCHMODE(1)
    ) dut (
        .CC_PosCOLLISION_CLOCK_50(clock),
        .CC_PosCOLLISION_RESET_InHigh(reset),
        .CC_PosCOLLISION_clear_InHigh(clear),
        .CC_PosCOLLISION_frametick_InHigh(tick),
        .CC_PosCOLLISION_fila0(fila0),
        .CC_PosCOLLISION_posjug(posjug),
        .CC_PosCOLLISION_OutBUS(ob1),
        .CC_PosCOLLISION_hit(hit1),
        .CC_PosCOLLISION_lives(lv1),
        .CC_PosCOLLISION_gameover(go1),
        .CC_PosCOLLISION_allover(all1)
    );

    cc_poscollision_monitor #(
        .PosCOLLISION_DATAWIDTH(8), .PosCOLLISION_NUMPLAYERS(2),
        .PosCOLLISION_LIVES(3), .PosCOLLISION_MATCHMODE(0)
    ) dutExact (
        .CC_PosCOLLISION_CLOCK_50(clock),
        .CC_PosCOLLISION_RESET_InHigh(reset),
        .CC_PosCOLLISION_clear_InHigh(clear),
        .CC_PosCOLLISION_frametick_InHigh(tick),
        .CC_PosCOLLISION_fila0(fila0),
        .CC_PosCOLLISION_posjug(posjug),
        .CC_PosCOLLISION_OutBUS(ob0),
        .CC_PosCOLLISION_hit(hit0),
        .CC_PosCOLLISION_lives(lv0),
        .CC_PosCOLLISION_gameover(go0),
        .CC_PosCOLLISION_allover(all0)
    );

    always #5 clock = ~clock;

    // Fresh game: full lives, no contact history, flags inactive.
    function automatic void modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 2; k++) begin
                mLives[m][k] = 3;
                mGo[m][k]    = 1'b0;
                mPrev[m][k]  = 1'b0;
                mOb[m][k]    = 1'b1;
                mHit[m][k]   = 1'b0;
            end
        end
    endfunction

    function automatic void modelStep(input bit clr, input bit tk, input logic [7:0] f,
                                      input logic [15:0] p);
        logic [7:0] pk;
        bit coll;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 2; k++) begin
                mHit[m][k] = 1'b0;
            end
        end
        if (clr) begin
            modelReset();
        end else if (tk) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 2; k++) begin
                    pk = p[k*8 +: 8];
                    if (m == 1) coll = (pk != 8'h00) && ((f & pk) != 8'h00);
                    else        coll = (pk != 8'h00) && (f == pk);
                    mOb[m][k] = !coll;
                    if (coll && !mPrev[m][k] && !mGo[m][k]) begin
                        mLives[m][k] = mLives[m][k] - 1;
                        mHit[m][k]   = 1'b1;
                        if (mLives[m][k] == 0) mGo[m][k] = 1'b1;
                    end
                    mPrev[m][k] = coll;
                end
            end
        end
    endfunction

    function automatic expT snapOne(input int m);
        expT e;
        e.ob  = {mOb[m][1], mOb[m][0]};
        e.hit = {mHit[m][1], mHit[m][0]};
        e.go  = {mGo[m][1], mGo[m][0]};
        e.lv  = {2'(mLives[m][1]), 2'(mLives[m][0])};
        e.all = mGo[m][1] && mGo[m][0];
        return e;
    endfunction

    function automatic pairT snapshot();
        pairT p;
        p.m1 = snapOne(1);
        p.m0 = snapOne(0);
        return p;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input pairT e);
        cmp("ovl.OutBUS", ob1, e.m1.ob);
        cmp("ovl.hit", hit1, e.m1.hit);
        cmp("ovl.lives", lv1, e.m1.lv);
        cmp("ovl.gameover", go1, e.m1.go);
        cmp("ovl.allover", all1, e.m1.all);
        cmp("eq.OutBUS", ob0, e.m0.ob);
        cmp("eq.hit", hit0, e.m0.hit);
        cmp("eq.lives", lv0, e.m0.lv);
        cmp("eq.gameover", go0, e.m0.go);
        cmp("eq.allover", all0, e.m0.all);
    endtask

    // Drive one cycle of inputs; expected response is queued for the monitor.
    task automatic applyStimulus(input bit clr, input bit tk, input logic [7:0] f,
                                 input logic [7:0] p0, input logic [7:0] p1);
        clear  = clr;
        tick   = tk;
        fila0  = f;
        posjug = {p1, p0};
        @(posedge clock);
        modelStep(clr, tk, f, {p1, p0});
        expQ.push_back(snapshot());
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic asyncResetCheck();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput(snapshot());
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every settled cycle has one pending expectation.
    always @(negedge clock) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] f, p0, p1;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput(snapshot());
        @(negedge clock);
        reset = 1'b0;

        // Single hit on player 0, then hit must drop.
        applyStimulus(1'b0, 1'b1, 8'h18, 8'h08, 8'h80);
        idle();
        // Continuous contact: no further deduction.
        repeat (4) applyStimulus(1'b0, 1'b1, 8'h18, 8'h08, 8'h80);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h08, 8'h80);
        applyStimulus(1'b0, 1'b1, 8'h18, 8'h08, 8'h80);
        // Drive player 0 to game over, then one more contact.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 8'h08, 8'h80);
            applyStimulus(1'b0, 1'b1, 8'h18, 8'h08, 8'h80);
        end
        // Player 1 three separated collisions.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 8'h08, 8'h10);
            applyStimulus(1'b0, 1'b1, 8'h18, 8'h00, 8'h10);
        end
        idle();
        // Exact-match rule and inactive player, after a clean restart.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h18, 8'h08, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h18, 8'h18, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        // Clear beats a colliding tick.
        applyStimulus(1'b1, 1'b1, 8'h18, 8'h18, 8'h18);
        idle();
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h01, 8'h02);
        asyncResetCheck();
        idle();

        for (int i = 0; i < 600; i++) begin
            f = 8'($urandom);
            p0 = ($urandom_range(0, 3) == 0) ? 8'h00 :
                 ($urandom_range(0, 2) == 0) ? f : 8'(1 << $urandom_range(0, 7));
            p1 = ($urandom_range(0, 3) == 0) ? 8'h00 :
                 ($urandom_range(0, 2) == 0) ? f : 8'(1 << $urandom_range(0, 7));
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, f, p0, p1);
            if (i % 200 == 150) asyncResetCheck();
        end
        idle();
        @(negedge clock);
        #1;
        cmp("queue.drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
